// File: rtl/mem_align_unit_pkg.sv
// Shared types and constants for the data-side memory alignment unit.
// Optional split support for misaligned accesses is enabled by MEM_ALIGN_SPLIT_EN.
package mem_align_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC0  = 3'd1,
        WAIT0 = 3'd2,
        ACC1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [BE_W-1:0] MASK_BYTE = 4'b0001;
    localparam logic [BE_W-1:0] MASK_HALF = 4'b0011;
    localparam logic [BE_W-1:0] MASK_WORD = 4'b1111;

    function automatic logic [BE_W-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_mask = MASK_BYTE;
            SZ_HALF: size_mask = MASK_HALF;
            SZ_WORD: size_mask = MASK_WORD;
            default: size_mask = '0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_shift.sv
// Byte-lane steering for the alignment unit: store enables/data across two words,
// load data right-justification, and legality/misalignment detection.
module mem_lane_shift
    import mem_align_unit_pkg::*;
(
    input  logic                  write_i,
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            off_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [2*DATA_W-1:0]   rbuf_i,
    output logic [2*BE_W-1:0]     be8_o,
    output logic [2*DATA_W-1:0]   wd64_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  misalign_o,
    output logic                  illegal_o
);

    logic [1:0] size;
    logic [5:0] shamt;

    assign size  = funct3_i[1:0];
    assign shamt = {off_i, 3'b000};

    assign be8_o   = {{BE_W{1'b0}}, size_mask(size)} << off_i;
    assign wd64_o  = {{DATA_W{1'b0}}, wdata_i} << shamt;
    assign rdata_o = DATA_W'(rbuf_i >> shamt);

    // Loads keep funct3[2] for the downstream extension stage; stores must have it clear.
    always_comb begin
        illegal_o  = 1'b0;
        misalign_o = 1'b0;
        if (write_i) begin
            illegal_o = !(funct3_i inside {F3_SB, F3_SH, F3_SW});
        end else begin
            illegal_o = !(funct3_i inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end
        misalign_o = ((size == SZ_HALF) && (off_i == 2'd3)) ||
                     ((size == SZ_WORD) && (off_i != 2'd0));
    end

endmodule

// File: rtl/mem_align_unit.sv
// Load/store sequencer onto the shared memory port with grant handshake.
// Define MEM_ALIGN_SPLIT_EN to run misaligned accesses as two word accesses.
module mem_align_unit
    import mem_align_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          f3_q, f3_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   buf_lo_q, buf_lo_d;

    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                idle_c;
    logic                cur_write;
    logic [ADDR_W-1:0]   cur_addr;
    logic [2:0]          cur_f3;
    logic [DATA_W-1:0]   cur_wdata;
    logic [2*BE_W-1:0]   be8_c;
    logic [2*DATA_W-1:0] wd64_c;
    logic [2*DATA_W-1:0] rbuf_c;
    logic [DATA_W-1:0]   rdata_c;
    logic                misalign_c;
    logic                illegal_c;
    logic                split_c;
    logic                reject_c;

    // While idle the lane logic looks at the live request so the first access can be launched on accept.
    assign idle_c    = (state_q == IDLE);
    assign cur_write = idle_c ? req_write  : wr_q;
    assign cur_addr  = idle_c ? req_addr   : addr_q;
    assign cur_f3    = idle_c ? req_funct3 : f3_q;
    assign cur_wdata = idle_c ? req_wdata  : wdata_q;

    assign req_ready = idle_c && !rst;
    assign buf_lo_d  = (state_q == WAIT0) ? mem_rdata : buf_lo_q;

`ifdef MEM_ALIGN_SPLIT_EN
    logic [DATA_W-1:0] buf_hi_q, buf_hi_d;

    assign buf_hi_d = (state_q == WAIT1) ? mem_rdata : buf_hi_q;
    assign rbuf_c   = {buf_hi_d, buf_lo_d};
    assign split_c  = misalign_c;
    assign reject_c = illegal_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_hi_q <= '0;
        end else begin
            buf_hi_q <= buf_hi_d;
        end
    end
`else
    logic unused_hi;

    assign rbuf_c    = {{DATA_W{1'b0}}, buf_lo_d};
    assign split_c   = 1'b0;
    assign reject_c  = illegal_c || misalign_c;
    assign unused_hi = ^{be8_c[2*BE_W-1:BE_W], wd64_c[2*DATA_W-1:DATA_W]};
`endif

    mem_lane_shift u_lane (
        .write_i    (cur_write),
        .funct3_i   (cur_f3),
        .off_i      (cur_addr[1:0]),
        .wdata_i    (cur_wdata),
        .rbuf_i     (rbuf_c),
        .be8_o      (be8_c),
        .wd64_o     (wd64_c),
        .rdata_o    (rdata_c),
        .misalign_o (misalign_c),
        .illegal_o  (illegal_c)
    );

    // Next state plus registered outputs, computed for the state being entered.
    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        f3_d         = f3_q;
        wdata_d      = wdata_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    f3_d    = req_funct3;
                    wdata_d = req_wdata;
                    state_d = reject_c ? RESP : ACC0;
                end
            end
            ACC0: begin
                if (mem_gnt) begin
                    if (!wr_q) begin
                        state_d = WAIT0;
                    end else begin
                        state_d = split_c ? ACC1 : RESP;
                    end
                end
            end
            WAIT0: state_d = split_c ? ACC1 : RESP;
`ifdef MEM_ALIGN_SPLIT_EN
            ACC1: begin
                if (mem_gnt) begin
                    state_d = wr_q ? RESP : WAIT1;
                end
            end
            WAIT1: state_d = RESP;
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mem_req_d = (state_d == ACC0) || (state_d == ACC1);
        if (idle_c && (state_d == ACC0)) begin
            mem_we_d    = cur_write;
            mem_addr_d  = {cur_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = be8_c[BE_W-1:0];
            mem_wdata_d = wd64_c[DATA_W-1:0];
        end
`ifdef MEM_ALIGN_SPLIT_EN
        if ((state_q != ACC1) && (state_d == ACC1)) begin
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            mem_be_d    = be8_c[2*BE_W-1:BE_W];
            mem_wdata_d = wd64_c[2*DATA_W-1:DATA_W];
        end
`endif

        resp_valid_d = (state_d == RESP);
        resp_err_d   = idle_c && (state_d == RESP);
        if ((state_d == RESP) && !idle_c && !wr_q) begin
            resp_rdata_d = rdata_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            f3_q         <= '0;
            wdata_q      <= '0;
            buf_lo_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            f3_q         <= f3_d;
            wdata_q      <= wdata_d;
            buf_lo_q     <= buf_lo_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_align_unit.sv
// Self-checking bench for mem_align_unit: vector table, memory responder with
// grant stalls, and a response scoreboard. Honours MEM_ALIGN_SPLIT_EN.
module tb_mem_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    mem_align_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] w0;
        logic [31:0] w1;
        int          stall;
        int          nacc;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] rdata;
        logic [31:0] rmask;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic [31:0] rmask;
        logic        err;
        int          cyc;
        int          lat;
    } sb_t;

    acc_t        acc_q[$];
    logic [31:0] rd_q[$];
    sb_t         sb_q[$];
    vec_t        vecs[$];
    int          stall_left = 0;
    logic        hold_valid = 1'b0;
    logic [68:0] hold_val;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] w0, input logic [31:0] w1,
                                input int stall, input int nacc,
                                input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                                input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                                input logic [31:0] rdata, input logic [31:0] rmask,
                                input logic err, input int lat);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.w0 = w0; v.w1 = w1;
        v.stall = stall; v.nacc = nacc;
        v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
        v.rdata = rdata; v.rmask = rmask; v.err = err; v.lat = lat;
        return v;
    endfunction

    // One cycle: memory responder and response monitor, both sampling at the falling edge.
    task automatic step();
        acc_t        e;
        sb_t         s;
        logic [68:0] cur;
        @(negedge clk);
        cur = {mem_we, mem_addr, mem_be, mem_wdata};
        if (mem_req) begin
            if (hold_valid) begin
                total++;
                if (cur !== hold_val) begin
                    bad++;
                    $display("FAIL hold: got 0x%0h, want 0x%0h", cur, hold_val);
                end
            end else begin
                hold_val   = cur;
                hold_valid = 1'b1;
            end
            if (stall_left > 0) begin
                mem_gnt = 1'b0;
                stall_left--;
            end else begin
                mem_gnt    = 1'b1;
                hold_valid = 1'b0;
                if (acc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_access: got addr 0x%0h, want none", mem_addr);
                end else begin
                    e = acc_q.pop_front();
                    chk("acc_we", 32'(mem_we), 32'(e.we));
                    chk("acc_addr", mem_addr, e.addr);
                    chk("acc_be", 32'(mem_be), 32'(e.be));
                    if (e.we) chk("acc_wdata", mem_wdata, e.wdata);
                end
                if (rd_q.size() > 0) mem_rdata = rd_q.pop_front();
                else mem_rdata = 32'h0;
            end
        end else begin
            mem_gnt    = 1'b0;
            hold_valid = 1'b0;
        end
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got resp_valid=1, want 0");
            end else begin
                s = sb_q.pop_front();
                chk($sformatf("v%0d_rdata", s.id), resp_rdata & s.rmask, s.rdata);
                chk($sformatf("v%0d_err", s.id), 32'(resp_err), 32'(s.err));
                chk($sformatf("v%0d_lat", s.id), 32'(cyc - s.cyc), 32'(s.lat));
            end
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        acc_t a;
        sb_t  s;
        step();
        chk($sformatf("v%0d_ready", id), 32'(req_ready), 32'd1);
        if (v.nacc > 0) begin
            a.we = v.wr; a.addr = v.a0; a.be = v.be0; a.wdata = v.wd0;
            acc_q.push_back(a);
            if (!v.wr) rd_q.push_back(v.w0);
        end
        if (v.nacc > 1) begin
            a.we = v.wr; a.addr = v.a1; a.be = v.be1; a.wdata = v.wd1;
            acc_q.push_back(a);
            if (!v.wr) rd_q.push_back(v.w1);
        end
        stall_left = v.stall;
        s.id = id; s.rdata = v.rdata; s.rmask = v.rmask; s.err = v.err; s.cyc = cyc; s.lat = v.lat;
        sb_q.push_back(s);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_addr   = v.addr;
        req_funct3 = v.f3;
        req_wdata  = v.wdata;
        step();
        req_valid  = 1'b0;
        req_write  = ~v.wr;
        req_addr   = ~v.addr;
        req_funct3 = 3'b011;
        req_wdata  = ~v.wdata;
        chk($sformatf("v%0d_busy", id), 32'(req_ready), 32'd0);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) step();
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL v%0d_timeout: got no resp_valid, want one within 40 cycles", id);
            sb_q.delete();
        end
        chk($sformatf("v%0d_acc_left", id), 32'(acc_q.size()), 32'd0);
        acc_q.delete();
        rd_q.delete();
        stall_left = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_funct3 = 3'b000;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rdata  = 32'h0;

        //   wr    f3      addr          wdata         w0            w1            st nacc a0            be0      wd0           a1            be1      wd1           rdata         rmask         err lat
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0,       0, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 3));
        vecs.push_back(mk(1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'h1122_3344, 32'h0,       0, 1, 32'h0000_0200, 4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_0011, 32'h0000_00FF, 1'b0, 3));
        vecs.push_back(mk(1'b1, 3'b000, 32'h0000_0202, 32'h1234_56AB, 32'h0,        32'h0,       0, 1, 32'h0000_0200, 4'b0100, 32'h56AB_0000, 32'h0,        4'b0000, 32'h0,        32'h0,         32'hFFFF_FFFF, 1'b0, 2));
        vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0101, 32'h0000_BEEF, 32'h0,        32'h0,       3, 1, 32'h0000_0100, 4'b0110, 32'h00BE_EF00, 32'h0,        4'b0000, 32'h0,        32'h0,         32'hFFFF_FFFF, 1'b0, 5));
        vecs.push_back(mk(1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        32'h0,       0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,         32'hFFFF_FFFF, 1'b1, 1));
        vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'hCAFE_1234, 32'h0,       0, 1, 32'h0000_0100, 4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_CAFE, 32'h0000_FFFF, 1'b0, 3));
        vecs.push_back(mk(1'b1, 3'b010, 32'h0000_0300, 32'h1234_5678, 32'h0,        32'h0,       1, 1, 32'h0000_0300, 4'b1111, 32'h1234_5678, 32'h0,        4'b0000, 32'h0,        32'h0,         32'hFFFF_FFFF, 1'b0, 3));
        vecs.push_back(mk(1'b1, 3'b100, 32'h0000_0300, 32'h1234_5678, 32'h0,        32'h0,       0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,         32'hFFFF_FFFF, 1'b1, 1));
        vecs.push_back(mk(1'b0, 3'b110, 32'h0000_0300, 32'h0,        32'h0,        32'h0,       0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,         32'hFFFF_FFFF, 1'b1, 1));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0401, 32'h0,        32'hA5B6_C7D8, 32'h0,       2, 1, 32'h0000_0400, 4'b0010, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_00C7, 32'h0000_00FF, 1'b0, 5));
`ifdef MEM_ALIGN_SPLIT_EN
        vecs.push_back(mk(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,        32'hAABB_CCDD, 32'h1122_3344, 0, 2, 32'hFFFF_FFFC, 4'b1100, 32'h0,      32'h0000_0000, 4'b0011, 32'h0,        32'h3344_AABB, 32'hFFFF_FFFF, 1'b0, 5));
        vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0103, 32'h0000_BEEF, 32'h0,        32'h0,       0, 2, 32'h0000_0100, 4'b1000, 32'hEF00_0000, 32'h0000_0104, 4'b0001, 32'h0000_00BE, 32'h0,      32'hFFFF_FFFF, 1'b0, 3));
        vecs.push_back(mk(1'b0, 3'b101, 32'h0000_00FF, 32'h0,        32'h1122_3344, 32'h5566_7788, 0, 2, 32'h0000_00FC, 4'b1000, 32'h0,      32'h0000_0100, 4'b0001, 32'h0,        32'h0000_8811, 32'h0000_FFFF, 1'b0, 5));
`else
        vecs.push_back(mk(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,        32'hAABB_CCDD, 32'h1122_3344, 0, 0, 32'h0,      4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,         32'hFFFF_FFFF, 1'b1, 1));
        vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0103, 32'h0000_BEEF, 32'h0,        32'h0,       0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,         32'hFFFF_FFFF, 1'b1, 1));
        vecs.push_back(mk(1'b0, 3'b101, 32'h0000_00FF, 32'h0,        32'h1122_3344, 32'h5566_7788, 0, 0, 32'h0,      4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,         32'hFFFF_FFFF, 1'b1, 1));
`endif

        // Reset values while rst is held.
        step();
        step();
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready_after", 32'(req_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Reset while stalled in ACC0: request drops at once and no response follows.
        step();
        stall_left = 1000;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h0000_0500;
        req_funct3 = 3'b010;
        step();
        req_valid = 1'b0;
        chk("mid_acc0_req", 32'(mem_req), 32'd1);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        step();
        step();
        rst        = 1'b0;
        stall_left = 0;
        #1;
        chk("mid_ready_after", 32'(req_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mid_no_resp", 32'(resp_valid), 32'd0);
        end

        run_vec(100, vecs[0]);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
